ifm_stream_gen: RTL and testbench

Raster-order input-feature-map streamer feeding the 3x3 line buffer. On `start` it reads one square W×W 8-bit feature-map plane from on-chip buffer memory and emits one pixel per cycle, contiguously, on `ifmstream_out`. It drives the line-buffer width select and flags the cycles where the downstream 3x3 window is fully inside the plane. It sits between the IFM buffer BRAM and the line buffer / PE array.

---
 rtl/ifm_stream_gen_if.sv | 33 +++
 rtl/ifm_stream_gen.sv | 170 +++++++++++++++++
 tb/tb_ifm_stream_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ifm_stream_gen_if.sv
// Memory read port plus pixel/window stream between the IFM streamer, the buffer BRAM and the line buffer.
// Fixed-latency signalling only: no ready/backpressure, the consumer must take every pixel.
interface ifm_stream_gen_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [2:0]        sel_out;
  logic [7:0]        ifmstream_out;
  logic              pix_valid;
  logic              win_valid;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rdata,
    output sel_out,
    output ifmstream_out,
    output pix_valid,
    output win_valid
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rdata,
    input  sel_out,
    input  ifmstream_out,
    input  pix_valid,
    input  win_valid
  );
endinterface

// File: rtl/ifm_stream_gen.sv
// Raster streamer: reads a WxW plane and emits one pixel/cycle; pixel p appears 3 cycles after start, window flag WIN_LAT later.
// No backpressure: reads are issued every FETCH cycle without gaps; starts outside IDLE are dropped.
module ifm_stream_gen #(
  parameter int ADDR_W  = 16,
  parameter int WIN_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        sel,
  input  logic [ADDR_W-1:0] base_addr,
  ifm_stream_gen_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PIPE_W = WIN_LAT + 2;
  localparam int DW     = $clog2(WIN_LAT + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_en_q, rd_en_d;
  logic [7:0]          row_q, row_d;
  logic [7:0]          col_q, col_d;
  logic                rvld_q, rvld_d;
  logic                pix_vld_q, pix_vld_d;
  logic [7:0]          pix_q, pix_d;
  logic [PIPE_W-1:0]   win_sr_q, win_sr_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [7:0]          wmax;
  logic                last_rd;
  logic                win_now;

  // W-1 for W = 8<<sel, i.e. a right-aligned mask of 3+sel ones.
  assign wmax    = 8'hFF >> (3'd5 - sel_q);
  assign last_rd = (row_q == wmax) && (col_q == wmax);
  assign win_now = rd_en_q && (row_q >= 8'd2) && (col_q >= 8'd2);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    rd_en_d   = rd_en_q;
    row_d     = row_q;
    col_d     = col_q;
    drain_d   = drain_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    // Read data arrives one cycle after the strobe and is registered once more.
    rvld_d    = rd_en_q;
    pix_vld_d = rvld_q;
    pix_d     = rvld_q ? bus.mem_rdata : 8'd0;
    win_sr_d  = {win_sr_q[PIPE_W-2:0], win_now};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (sel <= 3'd5) begin
            state_d = ST_FETCH;
            sel_d   = sel;
            addr_d  = base_addr;
            rd_en_d = 1'b1;
            row_d   = 8'd0;
            col_d   = 8'd0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_FETCH: begin
        if (last_rd) begin
          rd_en_d = 1'b0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (col_q == wmax) begin
            col_d = 8'd0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end

      // Two cycles of read pipeline plus WIN_LAT of window latency.
      ST_DRAIN: begin
        if (drain_q == DW'(WIN_LAT + 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      rvld_q    <= 1'b0;
      pix_vld_q <= 1'b0;
      pix_q     <= 8'd0;
      win_sr_q  <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rvld_q    <= rvld_d;
      pix_vld_q <= pix_vld_d;
      pix_q     <= pix_d;
      win_sr_q  <= win_sr_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_rd_en     = rd_en_q;
  assign bus.mem_addr      = addr_q;
  assign bus.sel_out       = sel_q;
  assign bus.ifmstream_out = pix_q;
  assign bus.pix_valid     = pix_vld_q;
  assign bus.win_valid     = win_sr_q[PIPE_W-1];
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_ifm_stream_gen.sv
// Bench for ifm_stream_gen: BRAM model with keyed contents, cycle-indexed expectations derived from pixel index p = r*W + c.
module tb_ifm_stream_gen;

  localparam int ADDR_W  = 16;
  localparam int WIN_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        sel = 3'd0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        key = 8'd0;

  int checks = 0;
  int failures = 0;

  ifm_stream_gen_if #(.ADDR_W(ADDR_W)) bus ();

  ifm_stream_gen #(
    .ADDR_W (ADDR_W),
    .WIN_LAT(WIN_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sel      (sel),
    .base_addr(base_addr),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // With key 0 the memory holds a[7:0]; other keys mix in the high byte.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return 8'(a[7:0] + key * a[15:8]);
  endfunction

  // Synchronous-read BRAM; garbage on the data bus when not reading.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem_val(bus.mem_addr);
    else               bus.mem_rdata <= 8'($urandom);
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a frame and watch it cycle by cycle. again>0 re-pulses start in that cycle;
  // abort_at>0 pulls reset in that cycle instead of finishing the frame.
  task automatic run_frame(input logic [2:0] s, input logic [15:0] b, input int again, input int abort_at);
    int w, n, d, p, q;
    int rd_err, addr_err, pix_err, win_err, busy_err, sel_err;
    int pv_cnt, wv_cnt, done_cnt, done_cyc, first_win, err_cnt, bad;
    logic exp_rd, exp_pv, exp_wv, exp_busy, aborted;
    logic [7:0] exp_pix;
    logic [15:0] last_addr;
    w = 8 << s; n = w * w; d = n + 3 + WIN_LAT;
    rd_err = 0; addr_err = 0; pix_err = 0; win_err = 0; busy_err = 0; sel_err = 0;
    pv_cnt = 0; wv_cnt = 0; done_cnt = 0; done_cyc = -1; first_win = -1; err_cnt = 0;
    last_addr = 16'h0; aborted = 1'b0;

    @(negedge clk);
    start = 1'b1; sel = s; base_addr = b;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      exp_rd = (k <= n);
      if (bus.mem_rd_en !== exp_rd) rd_err++;
      if (exp_rd) begin
        if (bus.mem_addr !== 16'(b + k - 1)) addr_err++;
        last_addr = bus.mem_addr;
      end
      p = k - 3;
      exp_pv  = (p >= 0) && (p < n);
      exp_pix = exp_pv ? mem_val(16'(b + p)) : 8'd0;
      if (bus.pix_valid !== exp_pv || bus.ifmstream_out !== exp_pix) pix_err++;
      if (bus.pix_valid) pv_cnt++;
      q = k - 3 - WIN_LAT;
      exp_wv = (q >= 0) && (q < n) && ((q / w) >= 2) && ((q % w) >= 2);
      if (bus.win_valid !== exp_wv) win_err++;
      if (bus.win_valid === 1'b1) begin
        wv_cnt++;
        if (first_win < 0) first_win = k;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = k; end
      exp_busy = (k <= d);
      if (busy !== exp_busy) busy_err++;
      if (bus.sel_out !== s) sel_err++;
      if (err !== 1'b0) err_cnt++;

      start = 1'b0; sel = 3'($urandom); base_addr = 16'($urandom);
      if (k == again) start = 1'b1;
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outputs",
                  {bus.mem_rd_en, bus.mem_addr, bus.sel_out, bus.ifmstream_out,
                   bus.pix_valid, bus.win_valid, busy, done, err}, 0);
        aborted = 1'b1;
        break;
      end
    end

    if (aborted) begin
      bad = 0;
      repeat (8) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.pix_valid !== 1'b0) bad++;
      end
      check_val("rst_hold_quiet", bad, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_release_idle", {busy, done, bus.mem_rd_en}, 0);
    end else begin
      check_val($sformatf("s%0d_rd_en_seq", s), rd_err, 0);
      check_val($sformatf("s%0d_addr_seq", s), addr_err, 0);
      check_val($sformatf("s%0d_last_addr", s), last_addr, 16'(b + n - 1));
      check_val($sformatf("s%0d_pix_seq", s), pix_err, 0);
      check_val($sformatf("s%0d_pix_count", s), pv_cnt, n);
      check_val($sformatf("s%0d_win_seq", s), win_err, 0);
      check_val($sformatf("s%0d_win_count", s), wv_cnt, (w - 2) * (w - 2));
      check_val($sformatf("s%0d_first_win_cyc", s), first_win, 2 * w + 2 + 3 + WIN_LAT);
      check_val($sformatf("s%0d_done_count", s), done_cnt, 1);
      check_val($sformatf("s%0d_done_cyc", s), done_cyc, n + 3 + WIN_LAT);
      check_val($sformatf("s%0d_busy_seq", s), busy_err, 0);
      check_val($sformatf("s%0d_sel_out", s), sel_err, 0);
      check_val($sformatf("s%0d_err_quiet", s), err_cnt, 0);
    end
  endtask

  task automatic bad_start(input logic [2:0] s, input logic [2:0] prev_sel);
    @(negedge clk);
    start = 1'b1; sel = s;
    @(negedge clk);
    check_val($sformatf("bad_sel%0d_err", s), err, 1);
    check_val($sformatf("bad_sel%0d_quiet", s), {busy, bus.mem_rd_en}, 0);
    check_val($sformatf("bad_sel%0d_sel_out", s), bus.sel_out, prev_sel);
    start = 1'b0;
    @(negedge clk);
    check_val($sformatf("bad_sel%0d_err_clear", s), err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rd_en", bus.mem_rd_en, 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_sel_out", bus.sel_out, 0);
    check_val("rst_pixel", bus.ifmstream_out, 0);
    check_val("rst_pix_valid", bus.pix_valid, 0);
    check_val("rst_win_valid", bus.win_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    key = 8'd0;
    run_frame(3'd0, 16'h0100, 0, 0);
    bad_start(3'd6, 3'd0);
    bad_start(3'd7, 3'd0);
    run_frame(3'd0, 16'hFFF0, 0, 0);

    key = 8'($urandom) | 8'd1;
    run_frame(3'd1, 16'($urandom), 20, 0);
    // start held through the DONE cycle only must not open a new frame
    run_frame(3'd1, 16'($urandom), 256 + 3 + WIN_LAT, 0);

    run_frame(3'd2, 16'($urandom), 0, 30);
    run_frame(3'd2, 16'($urandom), 0, 0);

    for (int i = 0; i < 4; i++) begin
      logic [2:0] rs;
      int rw;
      key = 8'($urandom);
      rs = 3'($urandom_range(0, 2));
      rw = 8 << rs;
      run_frame(rs, 16'($urandom), $urandom_range(1, rw * rw), 0);
    end

    key = 8'd0;
    run_frame(3'd5, 16'($urandom), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
